dmem_dump_streamer: RTL and testbench

- Hardware counterpart of the end-of-program memory dump: watches the CPU program counter for a halt address, freezes the core, then reads a window of data-memory words and streams them out over a valid/ready interface.
- Intended consumers are a UART/trace sink, or a bench monitor that checks results in silicon.
- Sits beside the top-level core and shares the data-memory read port while the core is frozen.

---
 rtl/dmem_dump_streamer.sv | 125 ++++++++++++
 tb/tb_dmem_dump_streamer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dump_streamer.sv
// End-of-program data-memory dump: freezes the core when pc hits END_PC, then reads
// NUM_WORDS words starting at START_WORD and streams them out over valid/ready.
module dmem_dump_streamer #(
    parameter int          ADDR_W         = 8,
    parameter int          DATA_W         = 32,
    parameter logic [31:0] END_PC         = 32'h78,
    parameter int          START_WORD     = 32,
    parameter int          NUM_WORDS      = 96,
    parameter int          WORDS_PER_LINE = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    output logic              cpu_halt,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_eol,
    output logic              m_last,
    output logic              done
);

    localparam int IDX_W = $clog2(NUM_WORDS) + 1;
    localparam int COL_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_WORD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_SEND,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [COL_W-1:0] col, col_nxt;   // idx mod WORDS_PER_LINE, avoids a divider
    logic             trigger;
    logic             hs;

    assign trigger  = (pc == END_PC);
    assign hs       = m_valid & m_ready;
    assign cpu_halt = (state != S_IDLE) | trigger;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        col_nxt   = col;
        case (state)
            S_IDLE: begin
                if (trigger) begin
                    state_nxt = S_ISSUE;
                    idx_nxt   = '0;
                    col_nxt   = '0;
                end
            end
            S_ISSUE:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_SEND;
            S_SEND: begin
                if (hs) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ISSUE;
                        idx_nxt   = idx + 1'b1;
                        col_nxt   = (col == COL_LAST) ? '0 : col + 1'b1;
                    end
                end
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            idx   <= '0;
            col   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            col   <= col_nxt;
        end
    end

    // Read port and stream registers; the read is launched on entry to ISSUE so
    // mem_rdata is ready to capture in CAPTURE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_re   <= 1'b0;
            mem_addr <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_eol    <= 1'b0;
            m_last   <= 1'b0;
            done     <= 1'b0;
        end else begin
            mem_re <= (state_nxt == S_ISSUE);
            if (state_nxt == S_ISSUE) begin
                mem_addr <= START_A + ADDR_W'(idx_nxt);
            end
            if (state == S_CAPTURE) begin
                m_data  <= mem_rdata;
                m_valid <= 1'b1;
                m_eol   <= (col == COL_LAST);
                m_last  <= (idx == LAST_IDX);
            end
            if (state == S_SEND && hs) begin
                m_valid <= 1'b0;
                if (idx == LAST_IDX) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_dump_streamer.sv
// Self-checking bench for dmem_dump_streamer: transaction-level model of the dump
// window plus directed timing, backpressure, reset and address-wrap scenarios.
module tb_dmem_dump_streamer;

    localparam int          N      = 96;
    localparam int          WPL    = 16;
    localparam int          START  = 32;
    localparam logic [31:0] END_PC = 32'h78;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc = '0;
    logic        cpu_halt, mem_re, m_valid, m_eol, m_last, done;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rdata = '0, m_data;
    logic        m_ready = 1'b1;

    logic [31:0] pc_w = '0;
    logic        cpu_halt_w, mem_re_w, m_valid_w, m_eol_w, m_last_w, done_w;
    logic [5:0]  mem_addr_w;
    logic [31:0] mem_rdata_w = '0, m_data_w;
    logic        m_ready_w = 1'b1;

    always #5 clk = ~clk;

    dmem_dump_streamer #(
        .ADDR_W(8), .DATA_W(32), .END_PC(END_PC), .START_WORD(START),
        .NUM_WORDS(N), .WORDS_PER_LINE(WPL)
    ) dut (
        .clk(clk), .reset(reset), .pc(pc), .cpu_halt(cpu_halt), .mem_re(mem_re),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_eol(m_eol), .m_last(m_last), .done(done)
    );

    dmem_dump_streamer #(
        .ADDR_W(6), .DATA_W(32), .END_PC(END_PC), .START_WORD(60),
        .NUM_WORDS(8), .WORDS_PER_LINE(4)
    ) dut_w (
        .clk(clk), .reset(reset), .pc(pc_w), .cpu_halt(cpu_halt_w), .mem_re(mem_re_w),
        .mem_addr(mem_addr_w), .mem_rdata(mem_rdata_w), .m_valid(m_valid_w), .m_ready(m_ready_w),
        .m_data(m_data_w), .m_eol(m_eol_w), .m_last(m_last_w), .done(done_w)
    );

    // Synchronous memories; data outside the 1-cycle read slot is garbage on purpose.
    logic [31:0] mem [0:255];
    always @(posedge clk) mem_rdata   <= mem_re   ? mem[mem_addr] : $urandom();
    always @(posedge clk) mem_rdata_w <= mem_re_w ? (32'hA000_0000 | 32'(mem_addr_w)) : $urandom();

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the dump is word k = mem[(START+k) mod 256], k = 0..N-1, in order.
    function automatic logic [7:0] exp_addr(input int k);
        return 8'((START + k) % 256);
    endfunction
    function automatic logic [31:0] exp_data(input int k);
        return mem[exp_addr(k)];
    endfunction
    function automatic logic exp_eol(input int k);
        return ((k + 1) % WPL) == 0;
    endfunction
    function automatic logic exp_last(input int k);
        return k == N - 1;
    endfunction

    bit trig = 1'b0;
    int acc = 0;
    int cyc = 0;
    int trig_edge = 0;
    int eol_seen = 0;
    int first_valid_neg = -1;
    int done_neg = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig     = 1'b0;
            acc      = 0;
            eol_seen = 0;
        end else if (!trig) begin
            if (pc == END_PC) begin
                trig      = 1'b1;
                trig_edge = cyc;
            end
        end else if (acc < N && m_valid && m_ready) begin
            if (m_eol) eol_seen++;
            acc++;
        end
    end

    always @(negedge clk) begin
        check("cpu_halt", 64'(cpu_halt), 64'(trig || pc == END_PC));
        check("done", 64'(done), 64'(trig && acc == N));
        if (!trig || acc == N) begin
            check("idle_m_valid", 64'(m_valid), 64'(0));
            check("idle_mem_re", 64'(mem_re), 64'(0));
        end
        if (mem_re) begin
            check("mem_addr", 64'(mem_addr), 64'(exp_addr(acc)));
            check("mem_re_while_valid", 64'(m_valid), 64'(0));
        end
        if (m_valid && trig && acc < N) begin
            check("m_data", 64'(m_data), 64'(exp_data(acc)));
            check("m_eol", 64'(m_eol), 64'(exp_eol(acc)));
            check("m_last", 64'(m_last), 64'(exp_last(acc)));
        end
        if (!reset) begin
            first_valid_neg = -1;
            done_neg        = -1;
        end else begin
            if (m_valid && first_valid_neg < 0) first_valid_neg = cyc;
            if (done && done_neg < 0) done_neg = cyc;
        end
    end

    logic [7:0]  w_addr_q [$];
    logic [33:0] w_word_q [$];
    always @(negedge clk) begin
        if (reset) begin
            if (mem_re_w) w_addr_q.push_back(8'(mem_addr_w));
            if (m_valid_w && m_ready_w) w_word_q.push_back({m_eol_w, m_last_w, m_data_w});
        end
    end

    bit rand_ready = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_dump_done(input string name, input int budget);
        int n = 0;
        while (acc < N && n < budget) begin
            step();
            n++;
        end
        check({"wait_", name}, 64'(acc == N), 64'(1));
    endtask

    initial begin
        int n;
        int wexp [8] = '{60, 61, 62, 63, 0, 1, 2, 3};

        for (int k = 0; k < 256; k++) mem[k] = 32'h1000 + 32'(k);
        reset = 1'b0;
        pc = END_PC;
        m_ready = 1'b1;

        check("pin_addr0", 64'(exp_addr(0)), 64'(32));
        check("pin_data10", 64'(exp_data(10)), 64'(32'h102A));
        check("pin_data95", 64'(exp_data(95)), 64'(32'h107F));
        check("pin_eol15", 64'(exp_eol(15)), 64'(1));
        check("pin_eol14", 64'(exp_eol(14)), 64'(0));
        check("pin_last95", 64'(exp_last(95)), 64'(1));

        repeat (3) step();
        check("rst_cpu_halt", 64'(cpu_halt), 64'(1));
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_data", 64'(m_data), 64'(0));
        check("rst_m_eol", 64'(m_eol), 64'(0));
        check("rst_m_last", 64'(m_last), 64'(0));
        check("rst_mem_re", 64'(mem_re), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_done", 64'(done), 64'(0));

        // Full dump with m_ready held high: exact 3-cycle cadence.
        reset = 1'b1;
        wait_dump_done("full", 400);
        step();
        check("first_valid_latency", 64'(first_valid_neg - trig_edge), 64'(3));
        check("done_latency", 64'(done_neg - trig_edge), 64'(3 * N + 1));
        check("eol_count", 64'(eol_seen), 64'(6));
        pc = 32'h0;
        repeat (5) step();
        check("halt_after_done", 64'(cpu_halt), 64'(1));

        // Backpressure on word 10, then random ready, then reset after word 40.
        reset = 1'b0;
        step();
        pc = END_PC;
        reset = 1'b1;
        n = 0;
        while (!(acc == 10 && m_valid) && n < 100) begin
            step();
            n++;
        end
        check("wait_word10", 64'(acc == 10 && m_valid), 64'(1));
        m_ready = 1'b0;
        repeat (5) begin
            step();
            check("bp_m_valid", 64'(m_valid), 64'(1));
            check("bp_m_data", 64'(m_data), 64'(32'h102A));
            check("bp_mem_re", 64'(mem_re), 64'(0));
        end
        m_ready = 1'b1;
        rand_ready = 1'b1;
        n = 0;
        while (acc < 41 && n < 1000) begin
            step();
            n++;
        end
        check("wait_word40", 64'(acc), 64'(41));
        check("pre_rst_mem_re", 64'(mem_re), 64'(1));
        reset = 1'b0;
        #1;
        check("mid_rst_m_valid", 64'(m_valid), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_mem_re", 64'(mem_re), 64'(0));
        check("mid_rst_mem_addr", 64'(mem_addr), 64'(0));
        step();
        step();
        reset = 1'b1;
        n = 0;
        while (!mem_re && n < 10) begin
            step();
            n++;
        end
        check("restart_addr", 64'(mem_addr), 64'(32));
        wait_dump_done("restart", 2000);

        // Random memory contents; near-miss pc, then a one-cycle trigger pulse.
        reset = 1'b0;
        step();
        for (int k = 0; k < 256; k++) mem[k] = $urandom();
        pc = 32'h74;
        reset = 1'b1;
        repeat (10) step();
        check("nearmiss_halt", 64'(cpu_halt), 64'(0));
        check("nearmiss_mem_re", 64'(mem_re), 64'(0));
        pc = END_PC;
        step();
        pc = 32'h7C;
        wait_dump_done("pulse", 2000);
        pc = END_PC;
        repeat (10) step();
        check("no_retrigger_done", 64'(done), 64'(1));
        check("no_retrigger_mem_re", 64'(mem_re), 64'(0));

        // Address wrap on the 6-bit instance.
        rand_ready = 1'b0;
        pc_w = END_PC;
        n = 0;
        while (!done_w && n < 100) begin
            step();
            n++;
        end
        check("wrap_done", 64'(done_w), 64'(1));
        check("wrap_addr_count", 64'(w_addr_q.size()), 64'(8));
        check("wrap_word_count", 64'(w_word_q.size()), 64'(8));
        for (int k = 0; k < 8; k++) begin
            if (k < w_addr_q.size())
                check($sformatf("wrap_addr%0d", k), 64'(w_addr_q[k]), 64'(wexp[k]));
            if (k < w_word_q.size())
                check($sformatf("wrap_word%0d", k), 64'(w_word_q[k]),
                      64'({(k % 4) == 3, k == 7, 32'hA000_0000 | 32'(wexp[k])}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
